// File: rtl/cnt_snap_pkg.sv
// cnt_snap_pkg: shared constants for the counter snapshot FIFO.
//   - word offsets of the Wishbone register map
//   - CTRL / STATUS bit positions
//   - value returned for undefined offsets and for DATA reads while empty
package cnt_snap_pkg;

    localparam int unsigned ADR_CTRL   = 0;
    localparam int unsigned ADR_PERIOD = 1;
    localparam int unsigned ADR_STATUS = 2;
    localparam int unsigned ADR_DATA   = 3;
    localparam int unsigned ADR_THRESH = 4;

    localparam int unsigned CTRL_EN_BIT      = 0;
    localparam int unsigned CTRL_FLUSH_BIT   = 1;
    localparam int unsigned CTRL_CLR_OVF_BIT = 2;

    localparam int unsigned STAT_EMPTY_BIT = 8;
    localparam int unsigned STAT_FULL_BIT  = 9;
    localparam int unsigned STAT_OVF_BIT   = 10;
    localparam int unsigned STAT_DROP_LSB  = 16;

    localparam logic [31:0] DEF_READ_VALUE = 32'hBADFABAC;

endpackage

// File: rtl/cnt_snap_sync_fifo.sv
// cnt_snap_sync_fifo: single-clock FIFO, depth 2**DEPTH_LOG2.
//   clk, rst     : clock, asynchronous active-high reset
//   push, din    : write request and data (accepted when not full, or when
//                  full and popping in the same cycle)
//   pop          : remove head (ignored when empty)
//   flush        : empty the FIFO; wins over push/pop
//   head         : current oldest entry
//   level        : entry count, DEPTH_LOG2+1 bits so full reads 2**DEPTH_LOG2
//   empty, full  : status flags
module cnt_snap_sync_fifo #(
    parameter int WIDTH      = 32,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  flush,
    input  logic [WIDTH-1:0]      din,
    output logic [WIDTH-1:0]      head,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  empty,
    output logic                  full
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int LW    = DEPTH_LOG2 + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [LW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [LW-1:0]    rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    // Pointers carry one extra wrap bit, so their difference is the level.
    assign level = wr_ptr_q - rd_ptr_q;
    assign empty = (level == '0);
    assign full  = (level == LW'(DEPTH));
    assign head  = mem[rd_ptr_q[DEPTH_LOG2-1:0]];

    // When full, a push is only accepted if the head leaves in the same cycle.
    assign do_push = push & (~full | pop);
    assign do_pop  = pop & ~empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + LW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + LW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr_q[DEPTH_LOG2-1:0]] <= din;
    end

endmodule

// File: rtl/cnt_snapshot_fifo.sv
// cnt_snapshot_fifo: Wishbone slave that samples count_i every max(PERIOD,1)
// cycles while enabled and buffers the samples in a FIFO read through DATA.
//   WB_CLK, WB_RST        : clock, asynchronous active-high reset
//   WBs_ADR/CYC/STB/WE    : Wishbone request (word offset, pre-decoded cycle)
//   WBs_BYTE_STB          : byte-lane write enables
//   WBs_WR_DAT/RD_DAT     : write data / registered read data
//   WBs_ACK               : one-cycle acknowledge, never back-to-back
//   count_i               : live counter value to sample
//   irq_o                 : level interrupt (only with CNT_SNAP_IRQ_EN)
// Optional macro CNT_SNAP_IRQ_EN adds the THRESH register and irq_o.
// Offsets: 0 CTRL, 1 PERIOD, 2 STATUS, 3 DATA (pop), 4 THRESH (macro only).
module cnt_snapshot_fifo
    import cnt_snap_pkg::*;
#(
    parameter int          ADDRWIDTH          = 7,
    parameter int          DATAWIDTH          = 32,
    parameter int          FIFO_DEPTH_LOG2    = 4,
    parameter logic [15:0] DEFAULT_PERIOD     = 16'd1000,
    parameter logic [31:0] DEFAULT_READ_VALUE = DEF_READ_VALUE
) (
    input  logic                 WB_CLK,
    input  logic                 WB_RST,
    input  logic [ADDRWIDTH-1:0] WBs_ADR,
    input  logic                 WBs_CYC,
    input  logic                 WBs_STB,
    input  logic                 WBs_WE,
    input  logic [3:0]           WBs_BYTE_STB,
    input  logic [DATAWIDTH-1:0] WBs_WR_DAT,
    output logic [DATAWIDTH-1:0] WBs_RD_DAT,
    output logic                 WBs_ACK,
    input  logic [DATAWIDTH-1:0] count_i
`ifdef CNT_SNAP_IRQ_EN
    ,
    output logic                 irq_o
`endif
);

    localparam int LW = FIFO_DEPTH_LOG2 + 1;

    logic                 ack_q, ack_d;
    logic [DATAWIDTH-1:0] rd_dat_q, rd_dat_d;
    logic                 enable_q, enable_d;
    logic [15:0]          period_q, period_d;
    logic [15:0]          cnt_q, cnt_d;
    logic                 ovf_q, ovf_d;
    logic [7:0]           drop_q, drop_d;

    logic                 acc, wr, rd;
    logic                 sel_ctrl, sel_period, sel_data;
    logic                 flush, clr_ovf, period_wr, pop, push, drop, tick;
    logic [15:0]          per_eff;
    logic [DATAWIDTH-1:0] status, rd_mux;

    logic [DATAWIDTH-1:0] fifo_head;
    logic [LW-1:0]        fifo_level;
    logic                 fifo_empty, fifo_full;

`ifdef CNT_SNAP_IRQ_EN
    logic [LW-1:0]        thresh_q, thresh_d;
    logic                 irq_q, irq_d;
    logic                 sel_thresh;
`endif

    logic unused_bits;
    assign unused_bits = ^{WBs_WR_DAT[DATAWIDTH-1:16], WBs_BYTE_STB[3:2]};

    // A new access is taken only while ACK is low, so ACK can never repeat.
    assign acc = WBs_CYC & WBs_STB & ~ack_q;
    assign wr  = acc & WBs_WE;
    assign rd  = acc & ~WBs_WE;

    assign sel_ctrl   = (WBs_ADR == ADDRWIDTH'(ADR_CTRL));
    assign sel_period = (WBs_ADR == ADDRWIDTH'(ADR_PERIOD));
    assign sel_data   = (WBs_ADR == ADDRWIDTH'(ADR_DATA));
`ifdef CNT_SNAP_IRQ_EN
    assign sel_thresh = (WBs_ADR == ADDRWIDTH'(ADR_THRESH));
`endif

    assign flush     = wr & sel_ctrl & WBs_BYTE_STB[0] & WBs_WR_DAT[CTRL_FLUSH_BIT];
    assign clr_ovf   = wr & sel_ctrl & WBs_BYTE_STB[0] & WBs_WR_DAT[CTRL_CLR_OVF_BIT];
    assign period_wr = wr & sel_period & (|WBs_BYTE_STB[1:0]);
    assign pop       = rd & sel_data & ~fifo_empty;

    // PERIOD of 0 behaves like 1: sample every cycle.
    assign per_eff = (period_q == 16'd0) ? 16'd1 : period_q;
    assign tick    = enable_q & (cnt_q == per_eff - 16'd1);

    // A tick during flush is thrown away and is not a drop.
    assign push = tick & ~flush & (~fifo_full | pop);
    assign drop = tick & ~flush & fifo_full & ~pop;

    cnt_snap_sync_fifo #(
        .WIDTH      (DATAWIDTH),
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    ) u_fifo (
        .clk   (WB_CLK),
        .rst   (WB_RST),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .din   (count_i),
        .head  (fifo_head),
        .level (fifo_level),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    always_comb begin
        status = '0;
        status[LW-1:0]                         = fifo_level;
        status[STAT_EMPTY_BIT]                 = fifo_empty;
        status[STAT_FULL_BIT]                  = fifo_full;
        status[STAT_OVF_BIT]                   = ovf_q;
        status[STAT_DROP_LSB+7:STAT_DROP_LSB]  = drop_q;
    end

    always_comb begin
        rd_mux = DEFAULT_READ_VALUE;
        case (WBs_ADR)
            ADDRWIDTH'(ADR_CTRL):   rd_mux = DATAWIDTH'(enable_q);
            ADDRWIDTH'(ADR_PERIOD): rd_mux = DATAWIDTH'(period_q);
            ADDRWIDTH'(ADR_STATUS): rd_mux = status;
            ADDRWIDTH'(ADR_DATA):   rd_mux = fifo_empty ? DEFAULT_READ_VALUE : fifo_head;
`ifdef CNT_SNAP_IRQ_EN
            ADDRWIDTH'(ADR_THRESH): rd_mux = DATAWIDTH'(thresh_q);
`endif
            default:                rd_mux = DEFAULT_READ_VALUE;
        endcase
    end

    always_comb begin
        ack_d    = acc;
        rd_dat_d = rd ? rd_mux : rd_dat_q;
        enable_d = enable_q;
        period_d = period_q;

        if (wr && sel_ctrl && WBs_BYTE_STB[0]) enable_d = WBs_WR_DAT[CTRL_EN_BIT];
        if (wr && sel_period) begin
            if (WBs_BYTE_STB[0]) period_d[7:0]  = WBs_WR_DAT[7:0];
            if (WBs_BYTE_STB[1]) period_d[15:8] = WBs_WR_DAT[15:8];
        end

        // Counter restarts on tick, on a PERIOD write, and whenever disabled.
        if (!enable_q || !enable_d || tick || period_wr) cnt_d = 16'd0;
        else                                            cnt_d = cnt_q + 16'd1;

        // Flush clears everything; a fresh drop beats clr_ovf.
        ovf_d  = ovf_q;
        drop_d = drop_q;
        if (flush) begin
            ovf_d  = 1'b0;
            drop_d = 8'd0;
        end else if (drop) begin
            ovf_d  = 1'b1;
            if (clr_ovf)              drop_d = 8'd1;
            else if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
        end else if (clr_ovf) begin
            ovf_d  = 1'b0;
            drop_d = 8'd0;
        end
    end

`ifdef CNT_SNAP_IRQ_EN
    always_comb begin
        thresh_d = thresh_q;
        if (wr && sel_thresh && WBs_BYTE_STB[0]) thresh_d = WBs_WR_DAT[LW-1:0];
        irq_d = ((thresh_q != '0) && (fifo_level >= thresh_q)) || ovf_q;
    end

    always_ff @(posedge WB_CLK or posedge WB_RST) begin
        if (WB_RST) begin
            thresh_q <= LW'(1);
            irq_q    <= 1'b0;
        end else begin
            thresh_q <= thresh_d;
            irq_q    <= irq_d;
        end
    end

    assign irq_o = irq_q;
`endif

    always_ff @(posedge WB_CLK or posedge WB_RST) begin
        if (WB_RST) begin
            ack_q    <= 1'b0;
            rd_dat_q <= '0;
            enable_q <= 1'b0;
            period_q <= DEFAULT_PERIOD;
            cnt_q    <= 16'd0;
            ovf_q    <= 1'b0;
            drop_q   <= 8'd0;
        end else begin
            ack_q    <= ack_d;
            rd_dat_q <= rd_dat_d;
            enable_q <= enable_d;
            period_q <= period_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            drop_q   <= drop_d;
        end
    end

    assign WBs_ACK    = ack_q;
    assign WBs_RD_DAT = rd_dat_q;

endmodule
